// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the fetch/data memory arbiter.
//   owner_e    : which requester a memory access belongs to
//   resp_tag_t : per-access bookkeeping carried down the response pipeline
//   WE_*       : memory write-enable codes (00 read, 01 byte, 10 half, 11 word)
package mem_arb_pkg;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   is_write;
   } resp_tag_t;

   localparam logic [1:0] WE_NONE = 2'b00;
   localparam logic [1:0] WE_BYTE = 2'b01;
   localparam logic [1:0] WE_HALF = 2'b10;
   localparam logic [1:0] WE_WORD = 2'b11;

   // Width of the starvation counter; StarveLimit must fit in it.
   localparam int StarveCntBits = 4;

   function automatic logic we_is_write(input logic [1:0] we);
      return we != WE_NONE;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the fetch port, the data port and the shared-memory port of the
//   arbiter. Signal suffixes are relative to the arbiter (_i = into arbiter).
//   modport slave  : the arbiter itself
//   modport master : the environment (fetch/data logic and memory macro)
//   Parameter RegBits : address/data width
interface mem_arbiter_if #(
   parameter int RegBits = 32
) ();
   // fetch port
   logic               if_req_i;
   logic [RegBits-1:0] if_addr_i;
   logic               if_gnt_o;
   logic               if_rvalid_o;
   logic [RegBits-1:0] if_rdata_o;
   // data port
   logic               dm_req_i;
   logic [RegBits-1:0] dm_addr_i;
   logic [1:0]         dm_we_i;
   logic [RegBits-1:0] dm_wdata_i;
   logic               dm_gnt_o;
   logic               dm_rvalid_o;
   logic [RegBits-1:0] dm_rdata_o;
   // shared memory port
   logic               mem_req_o;
   logic [RegBits-1:0] mem_addr_o;
   logic [1:0]         mem_we_o;
   logic [RegBits-1:0] mem_wdata_o;
   logic [RegBits-1:0] mem_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o,
      input  dm_req_i, dm_addr_i, dm_we_i, dm_wdata_i,
      output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
      output mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o,
      input  mem_rdata_i
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o,
      output dm_req_i, dm_addr_i, dm_we_i, dm_wdata_i,
      input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
      input  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o,
      output mem_rdata_i
   );
endinterface

// File: rtl/mem_arb_resp_pipe.sv
// mem_arb_resp_pipe
//   ReadLatency-deep shift register of response tags. A tag entering on
//   tag_i appears on tag_o exactly ReadLatency clock edges later, which is
//   when the memory presents the matching read data.
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low clear (drops everything in flight)
//   tag_i  : tag of the access granted this cycle (valid=0 when idle)
//   tag_o  : tag at the pipeline tail
module mem_arb_resp_pipe
   import mem_arb_pkg::*;
#(
   parameter int ReadLatency = 1
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  resp_tag_t tag_i,
   output resp_tag_t tag_o
);

   resp_tag_t [ReadLatency-1:0] stage_q;
   resp_tag_t [ReadLatency-1:0] stage_d;

   always_comb begin
      stage_d[0] = tag_i;
      for (int i = 1; i < ReadLatency; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign tag_o = stage_q[ReadLatency-1];

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between instruction fetch and data access.
//   Grants are combinational (request granted this cycle or it stalls); data
//   wins conflicts unless fetch has lost StarveLimit conflicts in a row.
//   Responses come back ReadLatency cycles after the grant, routed to the
//   owner; data writes get an ack with zero rdata.
//   Ports:
//     clk_i, rst_ni : clock, synchronous active-low reset
//     bus           : mem_arbiter_if.slave (fetch, data and memory ports)
//     conflict_cnt_o, starve_force_cnt_o : only with MEM_ARB_PERF_EN defined;
//                     cycles with both requests / cycles fetch won by starvation
//   Parameters: RegBits (width), ReadLatency (1..4), StarveLimit (1..15)
//   Build option: define MEM_ARB_PERF_EN to add the two performance counters.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int RegBits     = 32,
   parameter int ReadLatency = 1,
   parameter int StarveLimit = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   mem_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]   conflict_cnt_o,
   output logic [31:0]   starve_force_cnt_o
`endif
);

   localparam logic [StarveCntBits-1:0] StarveMax = StarveCntBits'(StarveLimit);

   logic [StarveCntBits-1:0] starve_cnt_q, starve_cnt_d;
   logic                     both_req;
   logic                     force_fetch;
   logic                     if_gnt, dm_gnt;
   logic [RegBits-1:0]       mem_addr, mem_wdata;
   logic [1:0]               mem_we;
   resp_tag_t                tag_in, tag_out;
   logic                     if_rvalid, dm_rvalid;

   always_comb begin
      both_req    = bus.if_req_i & bus.dm_req_i;
      force_fetch = both_req & (starve_cnt_q == StarveMax);
      // Grants are held low for the whole reset cycle, not just after it.
      if_gnt      = rst_ni & bus.if_req_i & (~bus.dm_req_i | force_fetch);
      dm_gnt      = rst_ni & bus.dm_req_i & ~if_gnt;

      starve_cnt_d = starve_cnt_q;
      if (if_gnt) begin
         starve_cnt_d = '0;
      end else if (both_req && (starve_cnt_q < StarveMax)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end

      // Fetch never writes; idle drives zeros on the memory port.
      mem_addr  = '0;
      mem_we    = WE_NONE;
      mem_wdata = '0;
      if (if_gnt) begin
         mem_addr = bus.if_addr_i;
      end else if (dm_gnt) begin
         mem_addr  = bus.dm_addr_i;
         mem_we    = bus.dm_we_i;
         mem_wdata = bus.dm_wdata_i;
      end

      tag_in.valid    = if_gnt | dm_gnt;
      tag_in.owner    = if_gnt ? OWN_FETCH : OWN_DATA;
      tag_in.is_write = dm_gnt & we_is_write(bus.dm_we_i);

      // Gating with rst_ni keeps responses silent during the reset cycle too.
      if_rvalid = rst_ni & tag_out.valid & (tag_out.owner == OWN_FETCH);
      dm_rvalid = rst_ni & tag_out.valid & (tag_out.owner == OWN_DATA);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

   mem_arb_resp_pipe #(
      .ReadLatency (ReadLatency)
   ) u_resp_pipe (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tag_i  (tag_in),
      .tag_o  (tag_out)
   );

   assign bus.if_gnt_o    = if_gnt;
   assign bus.dm_gnt_o    = dm_gnt;
   assign bus.mem_req_o   = if_gnt | dm_gnt;
   assign bus.mem_addr_o  = mem_addr;
   assign bus.mem_we_o    = mem_we;
   assign bus.mem_wdata_o = mem_wdata;

   assign bus.if_rvalid_o = if_rvalid;
   assign bus.if_rdata_o  = if_rvalid ? bus.mem_rdata_i : '0;
   assign bus.dm_rvalid_o = dm_rvalid;
   assign bus.dm_rdata_o  = (dm_rvalid && !tag_out.is_write) ? bus.mem_rdata_i : '0;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] conflict_cnt_q, conflict_cnt_d;
   logic [31:0] starve_force_cnt_q, starve_force_cnt_d;

   always_comb begin
      conflict_cnt_d     = conflict_cnt_q + {31'd0, both_req};
      starve_force_cnt_d = starve_force_cnt_q + {31'd0, force_fetch};
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         conflict_cnt_q     <= '0;
         starve_force_cnt_q <= '0;
      end else begin
         conflict_cnt_q     <= conflict_cnt_d;
         starve_force_cnt_q <= starve_force_cnt_d;
      end
   end

   assign conflict_cnt_o     = conflict_cnt_q;
   assign starve_force_cnt_o = starve_force_cnt_q;
`endif

endmodule
